aes_encrypt_iter: RTL

Iterative, handshaked AES encryption controller. It accepts one plaintext block and cipher key, then drives a single shared round datapath (encryptRound, or subBytes→shiftRows→addRoundKey for the final round) once per clock for Nr rounds. Round keys are taken from the combinational keyExpansion output. It is the area-optimised, clocked counterpart to the fully unrolled AES_Encrypt and slots behind a valid/ready stream source.

---
 rtl/aes_encrypt_iter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock over a shared round datapath,
// valid/ready on both sides, synchronous flush, and round keys from a combinational
// key expansion.
// Optional feature macro: AES_KEY_LATCH_EN. When it is defined, the cipher key is
// captured at accept so the source may change key while the block is in flight.
module aes_encrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  input  logic [N-1:0]   key,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);

  localparam int NW  = 4 * (Nr + 1);
  localparam int FKW = 128 * (Nr + 1);
  localparam logic [3:0] NR_LAST = 4'(Nr);

  // Forward S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i of the state lives at [127-8i -: 8]; bytes are column-major (row r, col c = r+4c).
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] rk);
    return mix_columns(shift_rows(sub_bytes(s))) ^ rk;
  endfunction

  // The last round skips MixColumns.
  function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] rk);
    return shift_rows(sub_bytes(s)) ^ rk;
  endfunction

  // Full schedule, round 0 key in the top 128 bits, round Nr key in [127:0].
  function automatic logic [FKW-1:0] key_expand(input logic [N-1:0] k);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [FKW-1:0] fk;
    rcon = 8'h01;
    t    = '0;
    for (int i = 0; i < Nk; i++) w[i] = k[N-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    fk = '0;
    for (int i = 0; i < NW; i++) fk[FKW-1-32*i -: 32] = w[i];
    return fk;
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_rc;
  logic [127:0]    r_st;
  logic [N-1:0]    w_key_src;
  logic [FKW-1:0]  w_fullkeys;
  logic [127:0]    w_rk;
  logic            w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef AES_KEY_LATCH_EN
  logic [N-1:0] r_key;

  // Capture the key with the block so the schedule no longer depends on the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_key <= '0;
    else if (w_accept) r_key <= key;
  end

  assign w_key_src = r_key;
`else
  assign w_key_src = key;
`endif

  assign w_fullkeys = key_expand(w_key_src);
  assign w_rk       = w_fullkeys[FKW-1 - 128*int'(r_rc) -: 128];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; flush outranks both round advance and output handoff.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_ROUND;
      S_ROUND: begin
        if (flush)                  w_state_next = S_IDLE;
        else if (r_rc == NR_LAST)   w_state_next = S_DONE;
      end
      S_DONE:  if (flush || out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // Round datapath: initial whitening on accept, then one round per cycle.
  // Round 0 key is the top 128 key bits, taken from the live key input at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= '0;
      r_rc <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st <= in_data ^ key[N-1 -: 128];
            r_rc <= 4'd1;
          end
        end
        S_ROUND: begin
          if (!flush) begin
            if (r_rc == NR_LAST) begin
              r_st <= final_round(r_st, w_rk);
            end else begin
              r_st <= encrypt_round(r_st, w_rk);
              r_rc <= r_rc + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_st;

endmodule
